// File: rtl/uart_regmap_pkg.sv
// Shared types and helpers for the UART byte register-map initiator.
package uart_regmap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_SEND_WAIT,
      ST_GAP,
      ST_RESP_HDR,
      ST_RESP_DATA,
      ST_FINISH
   } state_t;

   localparam int         RNW_BIT     = 7;
   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_HDR     = 2'd2;

   function automatic logic [7:0] make_hdr(input logic rnw, input logic [6:0] slave_id);
      logic [7:0] hdr;
      hdr          = {1'b0, slave_id};
      hdr[RNW_BIT] = rnw;
      return hdr;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counter that reloads while load is high and flags expiry after CYCLES enabled clocks.
module cycle_timer #(
   parameter int CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    cnt <= '0;
      else if (load)                 cnt <= CW'(CYCLES - 1);
      else if (enable && cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign expired = enable && (cnt == '0);

endmodule

// File: rtl/uart_byte_regmap_master.sv
// Host-side initiator: frames a read/write command onto uart_tx and checks/forwards the
// echoed header and read data arriving from uart_rx.
module uart_byte_regmap_master
   import uart_regmap_pkg::*;
#(
   parameter int NUM_ADDR_BYTES      = 1,
   parameter int GAP_CYCLES          = 2000,
   parameter int RESP_TIMEOUT_CYCLES = 20000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_read,
   input  logic [6:0]                  cmd_slave_id,
   input  logic [NUM_ADDR_BYTES*8-1:0] cmd_address,
   input  logic [7:0]                  cmd_len,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [7:0]                  wr_data,
   output logic                        rd_valid,
   output logic [7:0]                  rd_data,
   output logic                        done,
   output logic [1:0]                  error,
   output logic                        tx_trig,
   output logic [7:0]                  tx_data,
   input  logic                        tx_bsy,
   input  logic                        rx_data_valid,
   input  logic [7:0]                  rx_data
);
   localparam int AW      = NUM_ADDR_BYTES * 8;
   localparam int HDR_LEN = 1 + NUM_ADDR_BYTES;
   localparam int IDX_W   = $clog2(HDR_LEN + 257);

   state_t           state;
   logic             lat_read;
   logic [6:0]       lat_id;
   logic [AW-1:0]    lat_addr;
   logic [7:0]       lat_len;
   logic [IDX_W-1:0] byte_idx;
   logic [IDX_W-1:0] last_idx;
   logic [8:0]       rx_cnt;
   logic             hdr_seen;
   logic             skip_bsy;

   logic       data_byte;
   logic       in_resp;
   logic       rx_live;
   logic       hdr_match;
   logic       hdr_ok_now;
   logic [7:0] hdr_exp;
   logic [7:0] addr_byte;
   logic [7:0] next_byte;
   logic       gap_exp;
   logic       resp_exp;

   always_comb begin
      hdr_exp   = make_hdr(lat_read, lat_id);
      last_idx  = lat_read ? IDX_W'(HDR_LEN) : IDX_W'(HDR_LEN) + IDX_W'(lat_len);
      data_byte = !lat_read && (byte_idx >= IDX_W'(HDR_LEN));
      addr_byte = '0;
      for (int k = 0; k < NUM_ADDR_BYTES; k++)
         if (byte_idx == IDX_W'(k + 1)) addr_byte = lat_addr[(NUM_ADDR_BYTES-1-k)*8 +: 8];
      if (byte_idx == '0)                   next_byte = hdr_exp;
      else if (byte_idx < IDX_W'(HDR_LEN))  next_byte = addr_byte;
      else                                  next_byte = lat_len;
      in_resp    = (state == ST_RESP_HDR) || (state == ST_RESP_DATA);
      // the responder may answer while we are still sitting out the gap
      rx_live    = rx_data_valid && (in_resp || state == ST_GAP);
      hdr_match  = (rx_data == hdr_exp);
      hdr_ok_now = rx_live && !hdr_seen && hdr_match && lat_read;
   end

   assign wr_ready = (state == ST_SEND) && data_byte && !tx_bsy;

   cycle_timer #(.CYCLES(GAP_CYCLES)) u_gap_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (state != ST_GAP),
      .enable  (state == ST_GAP),
      .expired (gap_exp)
   );

   cycle_timer #(.CYCLES(RESP_TIMEOUT_CYCLES)) u_resp_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (!in_resp || rx_data_valid),
      .enable  (in_resp),
      .expired (resp_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b1;
         tx_trig   <= 1'b0;
         tx_data   <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         done      <= 1'b0;
         error     <= ERR_OK;
         lat_read  <= 1'b0;
         lat_id    <= '0;
         lat_addr  <= '0;
         lat_len   <= '0;
         byte_idx  <= '0;
         rx_cnt    <= '0;
         hdr_seen  <= 1'b0;
         skip_bsy  <= 1'b0;
      end else begin
         tx_trig  <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  lat_read  <= cmd_read;
                  lat_id    <= cmd_slave_id;
                  lat_addr  <= cmd_address;
                  lat_len   <= cmd_len;
                  error     <= ERR_OK;
                  byte_idx  <= '0;
                  rx_cnt    <= '0;
                  hdr_seen  <= 1'b0;
                  cmd_ready <= 1'b0;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!tx_bsy && (!data_byte || wr_valid)) begin
                  tx_trig  <= 1'b1;
                  tx_data  <= data_byte ? wr_data : next_byte;
                  byte_idx <= byte_idx + 1'b1;
                  skip_bsy <= 1'b1;
                  state    <= ST_SEND_WAIT;
               end
            end
            ST_SEND_WAIT: begin
               // uart_tx raises busy one clock after the trigger
               if (skip_bsy)     skip_bsy <= 1'b0;
               else if (!tx_bsy) state <= (byte_idx == last_idx + 1'b1) ? ST_GAP : ST_SEND;
            end
            ST_GAP: begin
               if (gap_exp) state <= (hdr_seen || hdr_ok_now) ? ST_RESP_DATA : ST_RESP_HDR;
            end
            ST_RESP_HDR, ST_RESP_DATA: begin
               if (resp_exp && !rx_data_valid) begin
                  error <= ERR_TIMEOUT;
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               done      <= 1'b1;
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // response bytes take priority over gap/timeout transitions above
         if (rx_live) begin
            if (!hdr_seen) begin
               if (!hdr_match) begin
                  error <= ERR_HDR;
                  state <= ST_FINISH;
               end else if (!lat_read) begin
                  state <= ST_FINISH;
               end else begin
                  hdr_seen <= 1'b1;
                  if (state == ST_RESP_HDR) state <= ST_RESP_DATA;
               end
            end else begin
               rd_valid <= 1'b1;
               rd_data  <= rx_data;
               rx_cnt   <= rx_cnt + 1'b1;
               if (rx_cnt == {1'b0, lat_len}) state <= ST_FINISH;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_byte_regmap_master.sv
// Randomized scoreboard bench: stimulus pushes expected tx bytes, read bytes and error codes;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_uart_byte_regmap_master;
   localparam int NAB = 2;
   localparam int GAP = 40;
   localparam int TO  = 100;
   localparam int AW  = NAB * 8;

   localparam int M_ECHO   = 0;
   localparam int M_SILENT = 1;
   localparam int M_BADHDR = 2;
   localparam int M_RSTMID = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_read = 1'b0;
   logic [6:0]    cmd_slave_id = '0;
   logic [AW-1:0] cmd_address = '0;
   logic [7:0]    cmd_len = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [7:0]    wr_data = '0;
   logic          rd_valid;
   logic [7:0]    rd_data;
   logic          done;
   logic [1:0]    error;
   logic          tx_trig;
   logic [7:0]    tx_data;
   logic          tx_bsy;
   logic          rx_data_valid = 1'b0;
   logic [7:0]    rx_data = '0;

   always #5 clk = ~clk;

   uart_byte_regmap_master #(
      .NUM_ADDR_BYTES(NAB), .GAP_CYCLES(GAP), .RESP_TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
      .cmd_slave_id(cmd_slave_id), .cmd_address(cmd_address), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .error(error),
      .tx_trig(tx_trig), .tx_data(tx_data), .tx_bsy(tx_bsy),
      .rx_data_valid(rx_data_valid), .rx_data(rx_data)
   );

   int passed = 0;
   int total  = 0;

   logic [7:0] exp_tx[$];
   logic [7:0] exp_rd[$];
   logic [1:0] exp_err[$];

   int cyc = 0;
   int tx_cnt = 0, rd_cnt = 0, done_cnt = 0;
   int last_trig_cyc = -100, done_cyc = 0;
   int stall_trigs = 0;
   bit stalling = 1'b0;
   int bcnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx stand-in: busy for a short random byte time starting the clock after a trigger
   always @(posedge clk) begin
      if (tx_trig)        bcnt <= 8 + $urandom_range(0, 4);
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign tx_bsy = (bcnt != 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      total++;
      $display("FAIL %s: got 0x%0h, required nothing/event", name, act);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_trig) begin
            chk("trig_while_idle_tx", tx_bsy, 0);
            chk("cmd_ready_low_busy", cmd_ready, 0);
            chk("trig_spacing", (cyc - last_trig_cyc) > 2, 1);
            if (exp_tx.size() == 0) fail("tx_unexpected", tx_data);
            else                    chk("tx_byte", tx_data, exp_tx.pop_front());
            if (stalling) stall_trigs++;
            tx_cnt++;
            last_trig_cyc = cyc;
         end
         if (rd_valid) begin
            if (exp_rd.size() == 0) fail("rd_unexpected", rd_data);
            else                    chk("rd_byte", rd_data, exp_rd.pop_front());
            rd_cnt++;
         end
         if (done) begin
            if (exp_err.size() == 0) fail("done_unexpected", error);
            else                     chk("error_code", error, exp_err.pop_front());
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic reset_outputs_chk();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_tx_trig", tx_trig, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
   endtask

   task automatic drive_cmd(input bit rd, input logic [6:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len);
      bit hs;
      int w = 0;
      cmd_valid = 1'b1; cmd_read = rd; cmd_slave_id = id; cmd_address = addr; cmd_len = len;
      do begin
         hs = cmd_ready;
         @(negedge clk);
         w++;
      end while (!hs && w < 1000);
      cmd_valid = 1'b0;
      if (!hs) fail("cmd_accept_timeout", w);
   endtask

   task automatic drive_wr(input logic [7:0] wq[$], input int stall_at);
      int i = 0, w = 0, st = stall_at;
      bit hs;
      if (wq.size() == 0) return;
      wr_valid = 1'b1; wr_data = wq[0];
      while (i < wq.size() && w < 20000) begin
         if (i == st) begin
            wr_valid = 1'b0;
            @(negedge clk);
            stalling = 1'b1;
            repeat (49) @(negedge clk);
            stalling = 1'b0;
            wr_valid = 1'b1;
            st = -1;
         end
         hs = wr_valid && wr_ready;
         @(negedge clk);
         w++;
         if (hs) begin
            i++;
            if (i < wq.size()) wr_data = wq[i];
            else               wr_valid = 1'b0;
         end
      end
      wr_valid = 1'b0;
      if (i < wq.size()) fail("wr_drain_timeout", i);
   endtask

   task automatic respond(input logic [7:0] rsp[$], input int target, input int min_dly);
      int w = 0;
      while (tx_cnt < target && w < 20000) begin @(negedge clk); w++; end
      if (tx_cnt < target) begin fail("frame_tx_timeout", tx_cnt); return; end
      @(negedge clk);
      w = 0;
      while (tx_bsy && w < 100) begin @(negedge clk); w++; end
      repeat (min_dly) @(negedge clk);
      foreach (rsp[k]) begin
         rx_data_valid = 1'b1; rx_data = rsp[k];
         @(negedge clk);
         rx_data_valid = 1'b0;
         repeat ($urandom_range(2, 15)) @(negedge clk);
      end
   endtask

   task automatic run_cmd(input bit rd, input logic [6:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input int mode, input int stall_at);
      logic [7:0] wq[$];
      logic [7:0] rsp[$];
      logic [7:0] b;
      int flen, t0, d0, r0, dly, w;
      flen = 1 + NAB + (rd ? 1 : int'(len) + 1);
      exp_tx.push_back({rd, id});
      for (int k = NAB - 1; k >= 0; k--) exp_tx.push_back(addr[k*8 +: 8]);
      if (rd) exp_tx.push_back(len);
      else for (int k = 0; k <= int'(len); k++) begin
         b = 8'($urandom);
         wq.push_back(b);
         exp_tx.push_back(b);
      end
      dly = 2 + $urandom_range(0, 68);
      case (mode)
         M_ECHO: begin
            rsp.push_back({rd, id});
            if (rd) for (int k = 0; k <= int'(len); k++) begin
               b = 8'($urandom);
               rsp.push_back(b);
               exp_rd.push_back(b);
            end
            exp_err.push_back(2'd0);
         end
         M_SILENT: exp_err.push_back(2'd1);
         M_BADHDR: begin
            // trailing bytes land after the command has ended and must be dropped
            rsp.push_back({rd, id ^ 7'h01});
            rsp.push_back(8'h5A);
            rsp.push_back(8'hC3);
            exp_err.push_back(2'd2);
         end
         default: begin
            rsp.push_back({rd, id});
            for (int k = 0; k < 3; k++) begin
               b = 8'($urandom);
               rsp.push_back(b);
               exp_rd.push_back(b);
            end
            dly = GAP + 5;
         end
      endcase
      t0 = tx_cnt; d0 = done_cnt; r0 = rd_cnt;
      fork
         drive_cmd(rd, id, addr, len);
         drive_wr(wq, stall_at);
         respond(rsp, t0 + flen, dly);
      join
      if (mode == M_RSTMID) begin
         w = 0;
         while (rd_cnt < r0 + 3 && w < 200) begin @(negedge clk); w++; end
         chk("rd_before_reset", rd_cnt - r0, 3);
         rst_n = 1'b0;
         #1;
         reset_outputs_chk();
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         repeat (20) @(negedge clk);
         chk("no_done_after_reset", done_cnt - d0, 0);
      end else begin
         w = 0;
         while (done_cnt == d0 && w < 20000) begin @(negedge clk); w++; end
         chk("done_count", done_cnt - d0, 1);
         if (mode == M_SILENT) begin
            chk("timeout_not_early", (done_cyc - last_trig_cyc) >= GAP + TO, 1);
            chk("timeout_not_late", (done_cyc - last_trig_cyc) <= GAP + TO + 30, 1);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit         rd;
      logic [6:0] id;
      logic [7:0] len;
      int         mode, st;

      repeat (2) @(negedge clk);
      reset_outputs_chk();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_cmd(1'b0, 7'd1, 16'h0005, 8'd0, M_ECHO, -1);
      run_cmd(1'b1, 7'd3, 16'h0010, 8'd3, M_ECHO, -1);
      run_cmd(1'b1, 7'd2, 16'h0020, 8'd0, M_SILENT, -1);
      run_cmd(1'b1, 7'd3, 16'h0030, 8'd3, M_BADHDR, -1);
      stall_trigs = 0;
      run_cmd(1'b0, 7'd5, 16'hBEEF, 8'd9, M_ECHO, 4);
      chk("no_trig_during_stall", stall_trigs, 0);
      run_cmd(1'b1, 7'd7, 16'h1234, 8'd7, M_RSTMID, -1);
      run_cmd(1'b1, 7'd9, 16'hA55A, 8'd2, M_ECHO, -1);
      run_cmd(1'b0, 7'h7F, 16'hFFFF, 8'd255, M_ECHO, -1);
      run_cmd(1'b1, 7'h40, 16'h0100, 8'd255, M_ECHO, -1);
      run_cmd(1'b0, 7'd4, 16'h0042, 8'd2, M_SILENT, -1);

      for (int n = 0; n < 12; n++) begin
         rd   = 1'($urandom_range(0, 1));
         id   = 7'($urandom);
         len  = 8'($urandom_range(0, 12));
         mode = ($urandom_range(0, 5) == 0) ? M_BADHDR : M_ECHO;
         st   = (!rd && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(len))) : -1;
         run_cmd(rd, id, 16'($urandom), len, mode, st);
      end

      chk("exp_tx_drained", exp_tx.size(), 0);
      chk("exp_rd_drained", exp_rd.size(), 0);
      chk("exp_err_drained", exp_err.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
